// File: rtl/dma_read_req_arbiter_pkg.sv
// Shared definitions for the DMA read request arbiter.
//  - FSM state encodings
//  - MRRS code to DW conversion
//  - DW/byte conversion and 4 KB page constants
//  - requester index type (up to 8 requesters)
package dma_read_req_arbiter_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCalc  = 2'd1;
  localparam logic [1:0] StIssue = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // One DW is 4 bytes.
  localparam int unsigned DwBytesLog2 = 2;
  // A 4 KB page holds 1024 DW.
  localparam logic [10:0] PageDw = 11'd1024;

  localparam int unsigned IdxW = 3;
  typedef logic [IdxW-1:0] req_idx_t;

  // PCIe device control [14:12] max read request size, in DW. Reserved codes fall back to the
  // smallest legal size.
  function automatic logic [10:0] mrrs_to_dw(input logic [2:0] code);
    logic [10:0] dw;
    case (code)
      3'd0:    dw = 11'd32;
      3'd1:    dw = 11'd64;
      3'd2:    dw = 11'd128;
      3'd3:    dw = 11'd256;
      3'd4:    dw = 11'd512;
      3'd5:    dw = 11'd1024;
      default: dw = 11'd32;
    endcase
    return dw;
  endfunction

endpackage

// File: rtl/dma_read_req_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches the request vector starting at ptr+1 (mod p_req) and returns the first set bit.
// Ports:
//  req      in   p_req  pending requests
//  ptr      in   3      index of the most recently served requester
//  gnt      out  p_req  one-hot grant
//  gnt_idx  out  3      binary index of the granted requester
//  gnt_any  out  1      at least one request is pending
module dma_read_req_arbiter_rr_arbiter
  import dma_read_req_arbiter_pkg::*;
#(
  parameter int unsigned p_req = 2
) (
  input  logic [p_req-1:0] req,
  input  req_idx_t         ptr,
  output logic [p_req-1:0] gnt,
  output req_idx_t         gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    int cand;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    // i = p_req wraps back to ptr itself, so a lone pending requester can still be re-served.
    for (int i = 1; i <= int'(p_req); i++) begin
      cand = int'(ptr) + i;
      if (cand >= int'(p_req)) begin
        cand = cand - int'(p_req);
      end
      for (int j = 0; j < int'(p_req); j++) begin
        if (!gnt_any && (cand == j) && req[j]) begin
          gnt_any = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = req_idx_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/dma_read_req_arbiter.sv
// Shares one DMA read request port between p_req requesters.
// A granted request is split into chunks no larger than min(MRRS, p_len_max) that never cross a
// 4 KB boundary. Each chunk accepted by the read engine is reported with its tag and owner so
// completions can be routed back.
// Ports:
//  i_clk, i_rst_n   clock, asynchronous active-low reset
//  pcie_dcommand    PCIe device control, [14:12] = MRRS code (sampled in CALC only)
//  req_addr/len     per-requester byte address (DW aligned) and DW length, 0 = empty request
//  req_valid        per-requester pending flag
//  req_done         per-requester 1-cycle pulse once the whole request has been issued
//  dma_read_*       chunk request to the read engine; valid held until dma_read_done
//  current_tag      tag the engine assigns on dma_read_done
//  tag_valid/out/owner  1-cycle report of each issued chunk's tag and owning requester
module dma_read_req_arbiter
  import dma_read_req_arbiter_pkg::*;
#(
  parameter int unsigned p_req     = 2,   // 2..8
  parameter int unsigned p_len_max = 512  // chunk cap in DW, at most 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [15:0]           pcie_dcommand,
  input  logic [32*p_req-1:0]   req_addr,
  input  logic [10*p_req-1:0]   req_len,
  input  logic [p_req-1:0]      req_valid,
  output logic [p_req-1:0]      req_done,
  output logic [31:0]           dma_read_addr,
  output logic [9:0]            dma_read_len,
  output logic                  dma_read_valid,
  input  logic                  dma_read_done,
  input  logic [7:0]            current_tag,
  output logic                  tag_valid,
  output logic [7:0]            tag_out,
  output logic [2:0]            tag_owner
);

  localparam req_idx_t    PtrRst = req_idx_t'(p_req - 1);
  localparam logic [10:0] LenMax = 11'(p_len_max);

  logic [1:0]       state_q, state_d;
  req_idx_t         gnt_q, gnt_d;
  req_idx_t         ptr_q, ptr_d;
  logic [31:0]      addr_q, addr_d;
  logic [9:0]       rem_q, rem_d;
  logic [9:0]       chunk_q, chunk_d;
  logic             valid_q, valid_d;
  logic [p_req-1:0] done_q, done_d;
  logic             tag_valid_q, tag_valid_d;
  logic [7:0]       tag_out_q, tag_out_d;
  req_idx_t         tag_owner_q, tag_owner_d;

  logic [p_req-1:0] arb_req;
  logic [p_req-1:0] arb_gnt;
  req_idx_t         arb_idx;
  logic             arb_any;

  logic [31:0]      sel_addr;
  logic [9:0]       sel_len;
  logic [10:0]      mrrs_dw;
  logic [10:0]      page_room;
  logic [10:0]      chunk_lim;

  // The requester just served sees req_done in the same cycle the FSM is back in IDLE, so its
  // req_valid is still high; mask it for that cycle to avoid serving the same request twice.
  assign arb_req = req_valid & ~done_q;

  dma_read_req_arbiter_rr_arbiter #(
    .p_req (p_req)
  ) u_rr_arbiter (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < int'(p_req); i++) begin
      if (arb_gnt[i]) begin
        sel_addr = req_addr[i*32 +: 32];
        sel_len  = req_len[i*10 +: 10];
      end
    end
  end

  // Chunk size: smallest of remaining length, MRRS, the fixed cap and the room left in the
  // current 4 KB page. The result never exceeds rem_q, so it fits in 10 bits.
  always_comb begin
    mrrs_dw   = mrrs_to_dw(pcie_dcommand[14:12]);
    page_room = PageDw - {1'b0, addr_q[11:2]};
    chunk_lim = {1'b0, rem_q};
    if (mrrs_dw < chunk_lim) begin
      chunk_lim = mrrs_dw;
    end
    if (LenMax < chunk_lim) begin
      chunk_lim = LenMax;
    end
    if (page_room < chunk_lim) begin
      chunk_lim = page_room;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    chunk_d     = chunk_q;
    valid_d     = valid_q;
    done_d      = '0;
    tag_valid_d = 1'b0;
    tag_out_d   = tag_out_q;
    tag_owner_d = tag_owner_q;

    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          gnt_d   = arb_idx;
          addr_d  = sel_addr & ~32'h3;
          rem_d   = sel_len;
          state_d = (sel_len == '0) ? StDone : StCalc;
        end
      end
      StCalc: begin
        chunk_d = chunk_lim[9:0];
        valid_d = 1'b1;
        state_d = StIssue;
      end
      StIssue: begin
        if (dma_read_done) begin
          valid_d     = 1'b0;
          tag_valid_d = 1'b1;
          tag_out_d   = current_tag;
          tag_owner_d = gnt_q;
          addr_d      = addr_q + (32'(chunk_q) << DwBytesLog2);
          rem_d       = rem_q - chunk_q;
          state_d     = (rem_q == chunk_q) ? StDone : StCalc;
        end
      end
      StDone: begin
        for (int i = 0; i < int'(p_req); i++) begin
          done_d[i] = (gnt_q == req_idx_t'(i));
        end
        ptr_d   = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      ptr_q       <= PtrRst;
      addr_q      <= '0;
      rem_q       <= '0;
      chunk_q     <= '0;
      valid_q     <= 1'b0;
      done_q      <= '0;
      tag_valid_q <= 1'b0;
      tag_out_q   <= '0;
      tag_owner_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      chunk_q     <= chunk_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      tag_valid_q <= tag_valid_d;
      tag_out_q   <= tag_out_d;
      tag_owner_q <= tag_owner_d;
    end
  end

  assign dma_read_addr  = addr_q;
  assign dma_read_len   = chunk_q;
  assign dma_read_valid = valid_q;
  assign req_done       = done_q;
  assign tag_valid      = tag_valid_q;
  assign tag_out        = tag_out_q;
  assign tag_owner      = tag_owner_q;

  logic unused_bits;
  assign unused_bits = ^{pcie_dcommand[15], pcie_dcommand[11:0], chunk_lim[10]};

endmodule

// File: tb/tb_dma_read_req_arbiter.sv
module tb_dma_read_req_arbiter;

  localparam int unsigned NReq = 2;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic [15:0]          pcie_dcommand;
  logic [32*NReq-1:0]   req_addr;
  logic [10*NReq-1:0]   req_len;
  logic [NReq-1:0]      req_valid;
  logic [NReq-1:0]      req_done;
  logic [31:0]          dma_read_addr;
  logic [9:0]           dma_read_len;
  logic                 dma_read_valid;
  logic                 dma_read_done;
  logic [7:0]           current_tag;
  logic                 tag_valid;
  logic [7:0]           tag_out;
  logic [2:0]           tag_owner;

  dma_read_req_arbiter #(
    .p_req     (NReq),
    .p_len_max (512)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .pcie_dcommand  (pcie_dcommand),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .req_valid      (req_valid),
    .req_done       (req_done),
    .dma_read_addr  (dma_read_addr),
    .dma_read_len   (dma_read_len),
    .dma_read_valid (dma_read_valid),
    .dma_read_done  (dma_read_done),
    .current_tag    (current_tag),
    .tag_valid      (tag_valid),
    .tag_out        (tag_out),
    .tag_owner      (tag_owner)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [9:0]  len;
    logic [2:0]  owner;
    logic        last;
  } chunk_t;

  typedef struct packed {
    logic [7:0]  tag;
    logic [2:0]  owner;
    logic [31:0] cyc;
  } tag_t;

  typedef struct packed {
    logic [2:0]        r;
    logic [31:0]       a;
    logic [9:0]        l;
    logic [2:0]        m;
    logic              drop;
    logic [2:0]        n;
    logic [3:0][31:0]  ca;
    logic [3:0][9:0]   cl;
  } vec_t;

  chunk_t     exp_chunk_q[$];
  tag_t       exp_tag_q[$];
  logic [2:0] exp_done_q[$];

  int          n_total = 0;
  int          n_pass  = 0;
  logic        eng_hold = 1'b0;
  logic        eng_busy = 1'b0;
  int          eng_wait = 0;
  chunk_t      cur;
  logic [7:0]  next_tag = 8'h11;
  int unsigned exp_valid_cyc = 0;
  int unsigned exp_done_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input string what);
    n_total++;
    $display("FAIL %s: %s", name, what);
  endtask

  // One cycle: read-engine model plus tag and req_done scoreboards, all sampled at negedge.
  task automatic tick();
    tag_t       tr;
    logic [2:0] di;
    int         remaining;
    @(negedge i_clk);
    if (dma_read_done) begin
      dma_read_done = 1'b0;
      current_tag   = 8'hEE;
      next_tag      = next_tag + 8'd1;
    end
    if (tag_valid) begin
      if (exp_tag_q.size() == 0) begin
        fail("tag_valid", $sformatf("unexpected pulse, tag 0x%0h, none required", tag_out));
      end else begin
        tr = exp_tag_q.pop_front();
        check("tag_out", tag_out, tr.tag);
        check("tag_owner", tag_owner, tr.owner);
        check("tag latency", cyc, tr.cyc + 1);
      end
    end
    if (req_done != '0) begin
      if (exp_done_q.size() == 0) begin
        fail("req_done", $sformatf("unexpected pulse 0x%0h, none required", req_done));
      end else begin
        di = exp_done_q.pop_front();
        check("req_done one-hot", req_done, NReq'(1) << di);
        check("req_done latency", cyc, exp_done_cyc);
        remaining = 0;
        foreach (exp_done_q[k]) if (exp_done_q[k] == di) remaining++;
        if (remaining == 0) req_valid = req_valid & ~(NReq'(1) << di);
      end
    end
    if (dma_read_valid && !eng_hold) begin
      if (!eng_busy) begin
        eng_busy = 1'b1;
        check("valid latency", cyc, exp_valid_cyc);
        if (exp_chunk_q.size() == 0) begin
          fail("chunk", $sformatf("unexpected chunk addr 0x%0h len %0d, none required",
                                  dma_read_addr, dma_read_len));
          cur = '{addr: dma_read_addr, len: dma_read_len, owner: 3'd0, last: 1'b1};
        end else begin
          cur = exp_chunk_q.pop_front();
          check("chunk addr", dma_read_addr, cur.addr);
          check("chunk len", dma_read_len, cur.len);
        end
        eng_wait = int'($urandom_range(0, 2));
      end
      if (eng_wait == 0) begin
        dma_read_done = 1'b1;
        current_tag   = next_tag;
        exp_tag_q.push_back('{tag: next_tag, owner: cur.owner, cyc: cyc});
        exp_valid_cyc = cyc + (cur.last ? 4 : 2);
        exp_done_cyc  = cyc + 2;
        eng_busy      = 1'b0;
      end else begin
        eng_wait--;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    logic idle;
    idle = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (exp_chunk_q.size() == 0 && exp_tag_q.size() == 0 && exp_done_q.size() == 0 &&
          !eng_busy && !dma_read_done) begin
        idle = 1'b1;
        break;
      end
      tick();
    end
    if (!idle) fail(name, $sformatf("%0d chunks, %0d tags, %0d dones still outstanding, required 0",
                                    exp_chunk_q.size(), exp_tag_q.size(), exp_done_q.size()));
    repeat (2) tick();
  endtask

  function automatic vec_t mk(input logic [2:0] r, input logic [31:0] a, input logic [9:0] l,
                              input logic [2:0] m, input logic d, input logic [2:0] n,
                              input logic [31:0] a0, input logic [9:0] l0,
                              input logic [31:0] a1, input logic [9:0] l1,
                              input logic [31:0] a2, input logic [9:0] l2,
                              input logic [31:0] a3, input logic [9:0] l3);
    vec_t v;
    v.r = r; v.a = a; v.l = l; v.m = m; v.drop = d; v.n = n;
    v.ca[0] = a0; v.cl[0] = l0; v.ca[1] = a1; v.cl[1] = l1;
    v.ca[2] = a2; v.cl[2] = l2; v.ca[3] = a3; v.cl[3] = l3;
    return v;
  endfunction

  initial begin
    vec_t vecs[7];
    logic seen;
    // req, addr, len, mrrs, drop, n, expected chunks (addr, len)
    vecs[0] = mk(0, 32'h0000_1000, 100, 0, 0, 4, 32'h1000, 32, 32'h1080, 32,
                 32'h1100, 32, 32'h1180, 4);
    vecs[1] = mk(1, 32'h0000_0FC0, 64, 5, 0, 2, 32'h0FC0, 16, 32'h1000, 48, 0, 0, 0, 0);
    vecs[2] = mk(1, 32'h0000_2003, 600, 5, 0, 2, 32'h2000, 512, 32'h2800, 88, 0, 0, 0, 0);
    vecs[3] = mk(0, 32'hFFFF_FFC0, 40, 2, 0, 2, 32'hFFFF_FFC0, 16, 32'h0, 24, 0, 0, 0, 0);
    vecs[4] = mk(1, 32'h0000_3000, 50, 6, 1, 2, 32'h3000, 32, 32'h3080, 18, 0, 0, 0, 0);
    vecs[5] = mk(0, 32'h0000_4000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6] = mk(0, 32'h0000_5000, 300, 3, 0, 2, 32'h5000, 256, 32'h5400, 44, 0, 0, 0, 0);

    pcie_dcommand = '0;
    req_addr      = '0;
    req_len       = '0;
    req_valid     = '0;
    dma_read_done = 1'b0;
    current_tag   = 8'hEE;
    i_rst_n       = 1'b0;

    tick();
    check("reset valid", dma_read_valid, 0);
    check("reset req_done", req_done, 0);
    check("reset tag", {tag_valid, tag_out, tag_owner}, 0);
    check("reset addr/len", {dma_read_addr, dma_read_len}, 0);
    i_rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      // Junk outside [14:12] must not matter.
      pcie_dcommand = {1'b1, vecs[v].m, 12'hA5A};
      if (vecs[v].r == 0) begin
        req_addr[31:0] = vecs[v].a;
        req_len[9:0]   = vecs[v].l;
      end else begin
        req_addr[63:32] = vecs[v].a;
        req_len[19:10]  = vecs[v].l;
      end
      for (int c = 0; c < int'(vecs[v].n); c++) begin
        exp_chunk_q.push_back('{addr: vecs[v].ca[c], len: vecs[v].cl[c], owner: vecs[v].r,
                                last: (c == int'(vecs[v].n) - 1)});
      end
      exp_done_q.push_back(vecs[v].r);
      exp_valid_cyc = cyc + 2;
      exp_done_cyc  = cyc + 2;
      req_valid = req_valid | (NReq'(1) << vecs[v].r);
      if (vecs[v].drop) begin
        // Withdrawing req_valid mid-request must not abort it.
        tick();
        tick();
        req_valid = req_valid & ~(NReq'(1) << vecs[v].r);
      end
      wait_idle($sformatf("vec%0d drain", v));
    end

    // A stray dma_read_done while idle must produce nothing.
    dma_read_done = 1'b1;
    current_tag   = 8'h77;
    tick();
    tick();
    check("idle done ignored", {tag_valid, dma_read_valid, req_done}, 0);

    // Reset in the middle of ISSUE. Last completed grant was requester 0, so only a restored
    // pointer lets requester 0 win first afterwards.
    eng_hold        = 1'b1;
    pcie_dcommand   = 16'h0000;
    req_addr[63:32] = 32'h6000;
    req_len[19:10]  = 10'd16;
    req_valid       = 2'b10;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (dma_read_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail("pre-reset issue", "dma_read_valid stayed 0, required 1");
    i_rst_n   = 1'b0;
    req_valid = '0;
    #1;
    check("mid-issue reset valid", dma_read_valid, 0);
    check("mid-issue reset req_done", req_done, 0);
    check("mid-issue reset tag", {tag_valid, tag_out, tag_owner}, 0);
    tick();
    i_rst_n  = 1'b1;
    eng_hold = 1'b0;

    // Both requesters held valid: grants must alternate 0,1,0,1.
    pcie_dcommand = 16'h2000;
    req_addr      = {32'h0000_7100, 32'h0000_7000};
    req_len       = {10'd8, 10'd8};
    for (int g = 0; g < 4; g++) begin
      exp_chunk_q.push_back('{addr: (g % 2 == 0) ? 32'h7000 : 32'h7100, len: 10'd8,
                              owner: 3'(g % 2), last: 1'b1});
      exp_done_q.push_back(3'(g % 2));
    end
    exp_valid_cyc = cyc + 2;
    req_valid     = 2'b11;
    wait_idle("alternate drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
